coin_frontend: RTL and testbench

COIN_FRONTEND -- requirements
Module: coin_frontend

---
 rtl/coin_frontend.sv | 183 ++++++++++++++++++
 tb/tb_coin_frontend.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_frontend.sv
// coin_frontend: synchronizes and debounces two coin sensors and a purchase
// key, then runs a small IDLE/COLLECT/DONE session FSM that accumulates credit.
// Optional feature: define COIN_TIMEOUT_EN to end a COLLECT session
// automatically after TIMEOUT idle cycles.
module coin_frontend #(
    parameter int DW       = 8,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_one_raw,
    input  logic          coin_ten_raw,
    input  logic          done_key_raw,
    output logic          coin_one_in_pulse,
    output logic          coin_ten_in_pulse,
    output logic          coin_reject_pulse,
    output logic          done,
    output logic          session_active,
    output logic [DW-1:0] credit
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int         NCH     = 3;  // bit 0: one coin, 1: ten coin, 2: done key
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_stable;
    logic [NCH-1:0] r_rise;
    logic [7:0]     r_db_cnt [NCH];

    state_t         r_state;
    logic [DW-1:0]  r_credit;
    logic           r_one_pulse;
    logic           r_ten_pulse;
    logic           r_reject_pulse;
    logic           r_done;
    logic           r_session;

    logic           w_one;
    logic           w_ten;
    logic           w_key;
    logic [DW:0]    w_sum_one;
    logic [DW:0]    w_sum_ten;
    logic           w_acc_one;
    logic           w_acc_ten;
    logic           w_rej;
    logic           w_timeout;

    // Two-flop synchronizer for all three raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
            // which is what builds the second flop stage.
            r_sync1 <= {done_key_raw, coin_ten_raw, coin_one_raw};
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: flip the stable value after DEBOUNCE consecutive mismatches,
    // emitting a one-cycle rise strobe on a 0->1 flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            r_rise   <= '0;
            for (int i = 0; i < NCH; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_rise[i] <= 1'b0;
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_rise[i]   <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_one     = r_rise[0];
    assign w_ten     = r_rise[1];
    assign w_key     = r_rise[2];
    assign w_sum_one = {1'b0, r_credit} + (DW+1)'(1);
    assign w_sum_ten = {1'b0, r_credit} + (DW+1)'(10);

    // Coin acceptance decisions for IDLE/COLLECT; a simultaneous pair or an
    // overflowing add turns the event into a reject.
    assign w_acc_one = w_one & ~w_ten & ~w_sum_one[DW];
    assign w_acc_ten = w_ten & ~w_one & ~w_sum_ten[DW];
    assign w_rej     = (w_one & w_ten) | (w_one & w_sum_one[DW]) | (w_ten & w_sum_ten[DW]);

`ifdef COIN_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_idle_cnt;

    // Idle counter: runs only in COLLECT, cleared by every accepted coin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_state != ST_COLLECT || w_acc_one || w_acc_ten) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_idle_cnt == TO_LAST) & ~w_acc_one & ~w_acc_ten;
`else
    assign w_timeout = 1'b0;
`endif

    // Session FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_one_pulse    <= 1'b0;
            r_ten_pulse    <= 1'b0;
            r_reject_pulse <= 1'b0;
            r_done         <= 1'b0;
            r_session      <= 1'b0;
        end else begin
            r_one_pulse    <= 1'b0;
            r_ten_pulse    <= 1'b0;
            r_reject_pulse <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COLLECT: begin
                    if (w_acc_one) begin
                        r_one_pulse <= 1'b1;
                        r_credit    <= w_sum_one[DW-1:0];
                    end
                    if (w_acc_ten) begin
                        r_ten_pulse <= 1'b1;
                        r_credit    <= w_sum_ten[DW-1:0];
                    end
                    r_reject_pulse <= w_rej;
                    // Coin is booked above first; done_key/timeout then closes.
                    if (r_state == ST_COLLECT && (w_key || w_timeout)) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_session <= 1'b0;
                    end else if (w_acc_one || w_acc_ten) begin
                        r_state   <= ST_COLLECT;
                        r_session <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_reject_pulse <= w_one | w_ten;
                    r_credit       <= '0;
                    r_state        <= ST_IDLE;
                    r_session      <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_session <= 1'b0;
                end
            endcase
        end
    end

    assign coin_one_in_pulse = r_one_pulse;
    assign coin_ten_in_pulse = r_ten_pulse;
    assign coin_reject_pulse = r_reject_pulse;
    assign done              = r_done;
    assign session_active    = r_session;
    assign credit            = r_credit;

endmodule

// File: tb/tb_coin_frontend.sv
// Directed testbench for coin_frontend (DW=8, DEBOUNCE=4, TIMEOUT=100).
module tb_coin_frontend;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coin_one_raw;
    logic          coin_ten_raw;
    logic          done_key_raw;
    logic          coin_one_in_pulse;
    logic          coin_ten_in_pulse;
    logic          coin_reject_pulse;
    logic          done;
    logic          session_active;
    logic [DW-1:0] credit;

    int errors = 0;
    int checks = 0;
    int n_one, n_ten, n_rej, n_done;
    int k;

    coin_frontend #(.DW(DW), .DEBOUNCE(4), .TIMEOUT(100)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .coin_one_raw      (coin_one_raw),
        .coin_ten_raw      (coin_ten_raw),
        .done_key_raw      (done_key_raw),
        .coin_one_in_pulse (coin_one_in_pulse),
        .coin_ten_in_pulse (coin_ten_in_pulse),
        .coin_reject_pulse (coin_reject_pulse),
        .done              (done),
        .session_active    (session_active),
        .credit            (credit)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and tallying pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_one  += int'(coin_one_in_pulse);
            n_ten  += int'(coin_ten_in_pulse);
            n_rej  += int'(coin_reject_pulse);
            n_done += int'(done);
        end
    endtask

    task automatic clr();
        n_one = 0; n_ten = 0; n_rej = 0; n_done = 0;
    endtask

    // Hold the selected raw inputs high for 8 cycles, then low for 8.
    task automatic insert(input logic one, input logic ten, input logic key);
        coin_one_raw = one; coin_ten_raw = ten; done_key_raw = key;
        tick(8);
        coin_one_raw = 1'b0; coin_ten_raw = 1'b0; done_key_raw = 1'b0;
        tick(8);
    endtask

    initial begin
        clr();
        rst_n = 1'b0; coin_one_raw = 1'b0; coin_ten_raw = 1'b0; done_key_raw = 1'b0;
        tick(3);
        check("rst_credit", 32'(credit), 0);
        check("rst_session", 32'(session_active), 0);
        check("rst_pulses", 32'({coin_one_in_pulse, coin_ten_in_pulse, coin_reject_pulse, done}), 0);
        rst_n = 1'b1;
        tick(2);

        // One coin held 10 cycles: pulse on the 7th sample (6 edges after first).
        clr();
        coin_one_raw = 1'b1;
        tick(6);
        check("one_early", 32'(n_one), 0);
        tick(1);
        check("one_pulse", 32'(coin_one_in_pulse), 1);
        check("one_credit", 32'(credit), 1);
        check("one_session", 32'(session_active), 1);
        tick(3);
        coin_one_raw = 1'b0;
        tick(8);
        check("one_count", 32'(n_one), 1);

        // Build up to 12 and press the purchase key for 8 cycles.
        insert(1'b0, 1'b1, 1'b0);
        insert(1'b1, 1'b0, 1'b0);
        check("credit12", 32'(credit), 12);
        clr();
        done_key_raw = 1'b1;
        tick(6);
        check("done_early", 32'(n_done), 0);
        tick(1);
        check("done_pulse", 32'(done), 1);
        check("done_credit_hold", 32'(credit), 12);
        tick(1);
        check("done_after", 32'(done), 0);
        check("done_credit_clr", 32'(credit), 0);
        check("done_idle", 32'(session_active), 0);
        done_key_raw = 1'b0;
        tick(8);
        check("done_count", 32'(n_done), 1);

        // 3-cycle glitch is filtered.
        clr();
        coin_ten_raw = 1'b1; tick(3); coin_ten_raw = 1'b0; tick(10);
        check("glitch_pulse", 32'(n_ten + n_rej), 0);
        check("glitch_credit", 32'(credit), 0);
        check("glitch_idle", 32'(session_active), 0);

        // 4-cycle pulse is exactly long enough.
        clr();
        coin_ten_raw = 1'b1; tick(4); coin_ten_raw = 1'b0; tick(10);
        check("min_pulse", 32'(n_ten), 1);
        check("min_credit", 32'(credit), 10);
        insert(1'b0, 1'b0, 1'b1);
        check("min_end", 32'(credit), 0);

        // Overflow boundary.
        for (int i = 0; i < 25; i++) insert(1'b0, 1'b1, 1'b0);
        check("credit250", 32'(credit), 250);
        clr();
        insert(1'b0, 1'b1, 1'b0);
        check("ovf_ten_rej", 32'(n_rej), 1);
        check("ovf_ten_nopulse", 32'(n_ten), 0);
        check("ovf_ten_credit", 32'(credit), 250);
        insert(1'b1, 1'b0, 1'b0);
        check("credit251", 32'(credit), 251);
        for (int i = 0; i < 4; i++) insert(1'b1, 1'b0, 1'b0);
        check("credit255", 32'(credit), 255);
        clr();
        insert(1'b1, 1'b0, 1'b0);
        check("ovf_one_rej", 32'(n_rej), 1);
        check("ovf_one_credit", 32'(credit), 255);
        insert(1'b0, 1'b0, 1'b1);

        // Both coins together.
        insert(1'b1, 1'b0, 1'b0);
        clr();
        insert(1'b1, 1'b1, 1'b0);
        check("both_rej", 32'(n_rej), 1);
        check("both_nopulse", 32'(n_one + n_ten), 0);
        check("both_credit", 32'(credit), 1);

        // Coin and key together: coin booked, then DONE.
        clr();
        coin_one_raw = 1'b1; done_key_raw = 1'b1;
        tick(7);
        check("coinc_pulse", 32'(coin_one_in_pulse), 1);
        check("coinc_done", 32'(done), 1);
        check("coinc_credit", 32'(credit), 2);
        tick(1);
        check("coinc_clr", 32'(credit), 0);
        coin_one_raw = 1'b0; done_key_raw = 1'b0;
        tick(8);

        // Coin arriving while in DONE is rejected.
        insert(1'b1, 1'b0, 1'b0);
        clr();
        done_key_raw = 1'b1;
        tick(1);
        coin_ten_raw = 1'b1;
        tick(6);
        check("indone_done", 32'(done), 1);
        tick(1);
        check("indone_rej", 32'(coin_reject_pulse), 1);
        check("indone_credit", 32'(credit), 0);
        done_key_raw = 1'b0; coin_ten_raw = 1'b0;
        tick(8);
        check("indone_noten", 32'(n_ten), 0);

        // Key in IDLE is ignored.
        clr();
        insert(1'b0, 1'b0, 1'b1);
        check("idle_key", 32'(n_done), 0);

        // Reset mid-session with coin still held.
        insert(1'b1, 1'b0, 1'b0);
        clr();
        coin_one_raw = 1'b1;
        tick(8);
        check("pre_rst_credit", 32'(credit), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_credit", 32'(credit), 0);
        check("mid_rst_session", 32'(session_active), 0);
        tick(2);
        rst_n = 1'b1;
        n_one = 0;
        tick(6);
        check("rerise_early", 32'(n_one), 0);
        tick(1);
        check("rerise_pulse", 32'(coin_one_in_pulse), 1);
        check("rerise_credit", 32'(credit), 1);
        check("rst_no_done", 32'(n_done), 0);
        coin_one_raw = 1'b0;
        tick(8);

        // Idle timeout (or its absence).
        clr();
        coin_one_raw = 1'b1;
        tick(7);
        check("to_coin", 32'(coin_one_in_pulse), 1);
        coin_one_raw = 1'b0;
`ifdef COIN_TIMEOUT_EN
        k = 0;
        while (k < 300 && n_done == 0) begin
            tick(1);
            k++;
        end
        check("to_latency", 32'(k), 100);
        tick(1);
        check("to_credit", 32'(credit), 0);
`else
        tick(1000);
        check("no_to_done", 32'(n_done), 0);
        check("no_to_session", 32'(session_active), 1);
        check("no_to_credit", 32'(credit), 2);
        insert(1'b0, 1'b0, 1'b1);
        check("no_to_end", 32'(credit), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
